promote_menu_ctrl: RTL and testbench

Sequences the pawn-promotion overlay: accepts a promotion request from game logic, waits for a frame boundary, then drives the 60×240 promotion sprite ROM address and the palette-select/highlight flags for the pixel path while the player moves a cursor over the four piece choices. On confirm, it returns the chosen piece to game logic through a valid/ready handshake. It sits between the move-validation logic and the VGA pixel mux, alongside the white and black promotion sprite ROMs.

---
 rtl/promote_menu_ctrl_pkg.sv | 30 +++
 rtl/promote_menu_ctrl_if.sv | 28 ++
 rtl/promote_menu_ctrl_addr_gen.sv | 71 +++++++
 rtl/promote_menu_ctrl.sv | 100 ++++++++++
 tb/tb_promote_menu_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/promote_menu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chess_pkg
// Purpose  : Shared piece/state encodings and promotion-sprite geometry.
// Revision : 1.0
// ============================================================================
package chess_pkg;

    typedef enum logic [1:0] {
        QUEEN  = 2'd0,
        ROOK   = 2'd1,
        BISHOP = 2'd2,
        KNIGHT = 2'd3
    } piece_e;

    typedef enum logic [1:0] {
        PS_IDLE   = 2'd0,
        PS_OPEN   = 2'd1,
        PS_SELECT = 2'd2,
        PS_COMMIT = 2'd3
    } promo_state_e;

    localparam int PROMO_W    = 60;
    localparam int PROMO_H    = 240;
    localparam int PROMO_BAND = 60;
    localparam int PROMO_X0   = 290;
    localparam int PROMO_Y0   = 120;

endpackage
`default_nettype wire

// File: rtl/promote_menu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : promote_menu_ctrl_if
// Purpose  : Request/result handshake between game logic and the promotion menu.
// Revision : 1.0
// ============================================================================
interface promote_menu_ctrl_if;
    import chess_pkg::*;

    logic   req_valid;
    logic   req_color;
    logic   req_ready;
    logic   done_valid;
    piece_e done_piece;
    logic   done_ready;

    modport master (
        output req_valid, req_color, done_ready,
        input  req_ready, done_valid, done_piece
    );

    modport slave (
        input  req_valid, req_color, done_ready,
        output req_ready, done_valid, done_piece
    );

endinterface
`default_nettype wire

// File: rtl/promote_menu_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : promote_addr_gen
// Purpose  : Overlay window test, sprite ROM address and cursor-band highlight.
// Revision : 1.0
// ============================================================================
module promote_addr_gen
    import chess_pkg::*;
#(
    parameter int SPRITE_W = PROMO_W,
    parameter int SPRITE_H = PROMO_H,
    parameter int BAND_H   = PROMO_BAND,
    parameter int ORIGIN_X = PROMO_X0,
    parameter int ORIGIN_Y = PROMO_Y0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        blank,
    input  logic [1:0]  cursor,
    output logic [13:0] rom_address,
    output logic        overlay_active,
    output logic        hl
);

    localparam logic [9:0]  X_LO  = 10'(ORIGIN_X);
    localparam logic [9:0]  X_HI  = 10'(ORIGIN_X + SPRITE_W);
    localparam logic [9:0]  Y_LO  = 10'(ORIGIN_Y);
    localparam logic [9:0]  Y_HI  = 10'(ORIGIN_Y + SPRITE_H);
    localparam logic [13:0] W_MUL = 14'(SPRITE_W);
    localparam logic [9:0]  BAND1 = 10'(BAND_H);
    localparam logic [9:0]  BAND2 = 10'(2 * BAND_H);
    localparam logic [9:0]  BAND3 = 10'(3 * BAND_H);

    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_in_win;
    logic [1:0] w_band;

    always_comb begin
        w_dx     = draw_x - X_LO;
        w_dy     = draw_y - Y_LO;
        w_in_win = enable && blank &&
                   (draw_x >= X_LO) && (draw_x < X_HI) &&
                   (draw_y >= Y_LO) && (draw_y < Y_HI);
        // Band index by threshold count avoids a divider for the 4 stacked bands.
        w_band   = {1'b0, (w_dy >= BAND1)} +
                   {1'b0, (w_dy >= BAND2)} +
                   {1'b0, (w_dy >= BAND3)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_address    <= '0;
            overlay_active <= 1'b0;
            hl             <= 1'b0;
        end else if (w_in_win) begin
            rom_address    <= 14'(w_dy) * W_MUL + 14'(w_dx);
            overlay_active <= 1'b1;
            hl             <= (w_band == cursor);
        end else begin
            rom_address    <= '0;
            overlay_active <= 1'b0;
            hl             <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/promote_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : promote_menu_ctrl
// Purpose  : Pawn-promotion overlay sequencer: request, frame sync, cursor, result.
// Revision : 1.0
// ============================================================================
module promote_menu_ctrl
    import chess_pkg::*;
#(
    parameter int SPRITE_W = PROMO_W,
    parameter int SPRITE_H = PROMO_H,
    parameter int BAND_H   = PROMO_BAND,
    parameter int ORIGIN_X = PROMO_X0,
    parameter int ORIGIN_Y = PROMO_Y0
) (
    input  logic                vga_clk,
    input  logic                reset,
    promote_menu_ctrl_if.slave  bus,
    input  logic                key_up,
    input  logic                key_down,
    input  logic                key_enter,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    output logic [13:0]         rom_address,
    output logic                rom_sel_black,
    output logic                overlay_active,
    output logic                hl
);

    promo_state_e state;
    logic [1:0]   cursor;

    assign bus.req_ready = (state == PS_IDLE);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state          <= PS_IDLE;
            cursor         <= 2'd0;
            rom_sel_black  <= 1'b0;
            bus.done_valid <= 1'b0;
            bus.done_piece <= QUEEN;
        end else begin
            case (state)
                PS_IDLE: begin
                    if (bus.req_valid) begin
                        rom_sel_black <= bus.req_color;
                        cursor        <= 2'd0;
                        state         <= PS_OPEN;
                    end
                end
                PS_OPEN: begin
                    if (DrawX == 10'd0 && DrawY == 10'd0) begin
                        state <= PS_SELECT;
                    end
                end
                PS_SELECT: begin
                    // Enter takes priority; a simultaneous up/down is dropped.
                    if (key_enter) begin
                        bus.done_piece <= piece_e'(cursor);
                        bus.done_valid <= 1'b1;
                        state          <= PS_COMMIT;
                    end else if (key_up && !key_down) begin
                        if (cursor != 2'd0) cursor <= cursor - 2'd1;
                    end else if (key_down && !key_up) begin
                        if (cursor != 2'd3) cursor <= cursor + 2'd1;
                    end
                end
                PS_COMMIT: begin
                    if (bus.done_ready) begin
                        bus.done_valid <= 1'b0;
                        state          <= PS_IDLE;
                    end
                end
                default: state <= PS_IDLE;
            endcase
        end
    end

    promote_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .BAND_H   (BAND_H),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y)
    ) u_addr_gen (
        .clk            (vga_clk),
        .rst            (reset),
        .enable         ((state == PS_SELECT) || (state == PS_COMMIT)),
        .draw_x         (DrawX),
        .draw_y         (DrawY),
        .blank          (blank),
        .cursor         (cursor),
        .rom_address    (rom_address),
        .overlay_active (overlay_active),
        .hl             (hl)
    );

endmodule
`default_nettype wire

// File: tb/tb_promote_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_promote_menu_ctrl
// Purpose  : Scoreboard bench for the promotion overlay sequencer.
// Revision : 1.0
// ============================================================================
module tb_promote_menu_ctrl;

    typedef struct {
        int addr;
        bit act;
        bit hl;
    } pix_t;

    logic        vga_clk;
    logic        reset;
    logic        key_up, key_down, key_enter;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [13:0] rom_address;
    logic        rom_sel_black, overlay_active, hl;

    promote_menu_ctrl_if bus();

    promote_menu_ctrl dut (
        .vga_clk        (vga_clk),
        .reset          (reset),
        .bus            (bus.slave),
        .key_up         (key_up),
        .key_down       (key_down),
        .key_enter      (key_enter),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .blank          (blank),
        .rom_address    (rom_address),
        .rom_sel_black  (rom_sel_black),
        .overlay_active (overlay_active),
        .hl             (hl)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    pix_t pix_q[$];
    int   res_q[$];
    bit   ov_en   = 1'b0;
    bit   in_sel  = 1'b0;
    int   tb_cursor = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    function automatic pix_t model_pix(int x, int y, bit b, bit en, int cur);
        pix_t p;
        p.addr = 0;
        p.act  = 1'b0;
        p.hl   = 1'b0;
        if (en && b && x >= 290 && x < 350 && y >= 120 && y < 360) begin
            p.addr = (y - 120) * 60 + (x - 290);
            p.act  = 1'b1;
            p.hl   = (((y - 120) / 60) == cur);
        end
        return p;
    endfunction

    task automatic pixel(input int x, input int y, input bit b, input string tag);
        pix_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        pix_q.push_back(model_pix(x, y, b, ov_en, tb_cursor));
        tick();
        e = pix_q.pop_front();
        check_val({tag, "_addr"}, 32'(rom_address), 32'(e.addr));
        check_val({tag, "_act"},  32'(overlay_active), 32'(e.act));
        check_val({tag, "_hl"},   32'(hl), 32'(e.hl));
    endtask

    task automatic press(input bit u, input bit d, input bit e);
        key_up    = u;
        key_down  = d;
        key_enter = e;
        if (in_sel) begin
            if (e) begin
                res_q.push_back(tb_cursor);
                in_sel = 1'b0;
            end else if (u && !d) begin
                if (tb_cursor > 0) tb_cursor--;
            end else if (d && !u) begin
                if (tb_cursor < 3) tb_cursor++;
            end
        end
        tick();
        key_up    = 1'b0;
        key_down  = 1'b0;
        key_enter = 1'b0;
    endtask

    task automatic accept(input bit color);
        bus.req_valid = 1'b1;
        bus.req_color = color;
        tick();
        bus.req_valid = 1'b0;
        tb_cursor = 0;
        check_val("accept_ready", 32'(bus.req_ready), 32'd0);
        check_val("accept_color", 32'(rom_sel_black), 32'(color));
    endtask

    task automatic frame_start();
        pixel(0, 0, 1'b1, "frame0");
        ov_en  = 1'b1;
        in_sel = 1'b1;
    endtask

    task automatic check_result(input string tag);
        int exp_piece;
        check_val({tag, "_valid"}, 32'(bus.done_valid), 32'd1);
        if (res_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_piece = res_q.pop_front();
            check_val({tag, "_piece"}, 32'(bus.done_piece), 32'(exp_piece));
            res_q.push_front(exp_piece);
        end
    endtask

    initial begin
        reset         = 1'b1;
        key_up        = 1'b0;
        key_down      = 1'b0;
        key_enter     = 1'b0;
        DrawX         = 10'd5;
        DrawY         = 10'd5;
        blank         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_color = 1'b0;
        bus.done_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_done_valid", 32'(bus.done_valid), 32'd0);
        check_val("rst_done_piece", 32'(bus.done_piece), 32'd0);
        check_val("rst_sel_black", 32'(rom_sel_black), 32'd0);
        check_val("rst_addr", 32'(rom_address), 32'd0);
        check_val("rst_act", 32'(overlay_active), 32'd0);
        check_val("rst_hl", 32'(hl), 32'd0);

        accept(1'b1);
        pixel(290, 120, 1'b1, "open_win");
        press(1'b0, 1'b1, 1'b0);
        pixel(300, 130, 1'b1, "open_key");
        frame_start();
        pixel(290, 120, 1'b1, "origin");
        pixel(349, 359, 1'b1, "far_corner");
        pixel(350, 120, 1'b1, "right_edge");
        pixel(289, 200, 1'b1, "left_edge");
        pixel(300, 130, 1'b0, "blanked");

        for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0);
        pixel(300, 300, 1'b1, "cur3_band3");
        press(1'b1, 1'b1, 1'b0);
        pixel(300, 359, 1'b1, "updn_band3");
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
        pixel(300, 130, 1'b1, "cur0_band0");
        pixel(300, 180, 1'b1, "cur0_band1");

        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        pixel(300, 240, 1'b1, "cur2_row240");
        pixel(300, 239, 1'b1, "cur2_row239");
        pixel(300, 299, 1'b1, "cur2_row299");

        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        check_result("enter");
        for (int i = 0; i < 10; i++) begin
            pixel(290, 180, 1'b1, "hold_pix");
            check_result("hold");
        end
        void'(res_q.pop_front());
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        ov_en = 1'b0;
        check_val("hs_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("hs_done_valid", 32'(bus.done_valid), 32'd0);

        accept(1'b0);
        frame_start();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check_result("enter2");
        res_q.delete();

        DrawX = 10'd300;
        DrawY = 10'd130;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        ov_en  = 1'b0;
        in_sel = 1'b0;
        tb_cursor = 0;
        check_val("rst2_done_valid", 32'(bus.done_valid), 32'd0);
        check_val("rst2_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst2_act", 32'(overlay_active), 32'd0);

        DrawX = 10'd0;
        DrawY = 10'd0;
        accept(1'b1);
        pixel(290, 120, 1'b1, "wait_frame");
        frame_start();
        pixel(290, 120, 1'b1, "after_rst");

        check_val("sb_drained", 32'(pix_q.size() + res_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
